// File: rtl/keypad_scan_rx_if.sv
// keypad_scan_rx_if
//   Key-event handshake between the keypad receiver (master) and the
//   control logic consuming key events (slave).
//   key_code  : accepted key, col*4 + row
//   key_valid : key_code holds an unacknowledged event
//   key_ack   : consumer acknowledge, ignored while key_valid is 0
//   key_down  : debounced "exactly one key held" level
//   overrun   : sticky, an event was dropped while key_valid was high
interface keypad_scan_rx_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  modport master (
    output key_code, key_valid, key_down, overrun,
    input  key_ack
  );

  modport slave (
    input  key_code, key_valid, key_down, overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_scan_rx.sv
// keypad_scan_rx
//   Matrix-keypad receiver. Strobes four active-low columns, samples the
//   active-low rows through a 2-flop synchronizer, debounces the 16-key
//   frame snapshot and turns a single held key into a key event on the
//   valid/ack handshake.
// Ports:
//   clk       : system clock, rising edge
//   cpu_reset : synchronous active-high reset
//   row_in    : keypad rows, active-low, asynchronous to clk
//   col_out   : column strobe, active-low one-hot
//   kp        : key event handshake (keypad_scan_rx_if.master)
// Parameters: SCAN_DIV (cycles per column, >=2), DEBOUNCE (1..15 frames),
//   REPEAT_FRAMES (auto-repeat period in frames).
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a
//   single key is held.
module keypad_scan_rx #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 50
) (
  input  logic               clk,
  input  logic               cpu_reset,
  input  logic [3:0]         row_in,
  output logic [3:0]         col_out,
  keypad_scan_rx_if.master   kp
);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("DEBOUNCE must be in 1..15");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("REPEAT_FRAMES must be at least 1");
  end

  localparam int unsigned     CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_MAX    = 4'(DEBOUNCE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_MULTI = 2'd2;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   raw_q, raw_d;
  logic [15:0]   prev_q, prev_d;
  logic [3:0]    stable_q, stable_d;
  logic [15:0]   deb_q, deb_d;
  logic          deb_upd_q, deb_upd_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic          sample, frame_done;
  logic          one_hot;
  logic [3:0]    deb_idx;
  logic          ev;
  logic [3:0]    ev_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned         RW       = $clog2(2 * REPEAT_FRAMES + 1);
  localparam logic [RW-1:0]       REP_LAST = RW'(2 * REPEAT_FRAMES - 1);
  localparam logic [RW-1:0]       REP_BASE = RW'(REPEAT_FRAMES);
  logic          frame_q;
  logic [RW-1:0] rep_q, rep_d;
`endif

  // Column scan, raw snapshot and frame debounce.
  always_comb begin
    sample     = (dwell_q == DWELL_LAST);
    frame_done = sample && (col_q == 2'd3);
    dwell_d    = sample ? '0 : dwell_q + 1'b1;
    col_d      = sample ? col_q + 2'd1 : col_q;
    raw_d      = raw_q;
    if (sample) begin
      raw_d[{col_q, 2'b00} +: 4] = ~row_s2_q;
    end
    stable_d  = stable_q;
    prev_d    = prev_q;
    deb_d     = deb_q;
    deb_upd_d = 1'b0;
    if (frame_done) begin
      if (raw_d == prev_q) begin
        if (stable_q < DEB_MAX) stable_d = stable_q + 4'd1;
      end else begin
        stable_d = 4'd1;
        prev_d   = raw_d;
      end
      // Update only on the transition into saturation; with DEBOUNCE=1 a
      // changed frame is itself that transition.
      if (stable_d == DEB_MAX && (stable_q < DEB_MAX || raw_d != prev_q)) begin
        deb_d     = raw_d;
        deb_upd_d = 1'b1;
      end
    end
  end

  // Key FSM, optional repeat and event handshake, one cycle after deb update.
  always_comb begin
    one_hot = (deb_q != '0) && ((deb_q & (deb_q - 16'd1)) == '0);
    deb_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (deb_q[i]) deb_idx = 4'(i);
    end
    state_d = state_q;
    held_d  = held_q;
    ev      = 1'b0;
    ev_code = deb_idx;
    case (state_q)
      ST_IDLE: if (deb_upd_q) begin
        if (one_hot) begin
          state_d = ST_HELD;
          held_d  = deb_idx;
          ev      = 1'b1;
        end else if (deb_q != '0) begin
          state_d = ST_MULTI;
        end
      end
      ST_HELD: if (deb_upd_q) begin
        if (deb_q == '0)                        state_d = ST_IDLE;
        else if (deb_q != (16'd1 << held_q))    state_d = ST_MULTI;
      end
      ST_MULTI: if (deb_upd_q && deb_q == '0)   state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
`ifdef KEYPAD_REPEAT_EN
    rep_d = rep_q;
    if (state_d != ST_HELD) begin
      rep_d = '0;
    end else if (state_q == ST_HELD && frame_q) begin
      if (rep_q == REP_LAST) begin
        ev      = 1'b1;
        ev_code = held_q;
        rep_d   = REP_BASE;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (ev) begin
      if (!valid_q || kp.key_ack) begin
        code_d  = ev_code;
        valid_d = 1'b1;
        if (valid_q) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (kp.key_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      row_s1_q  <= '1;
      row_s2_q  <= '1;
      dwell_q   <= '0;
      col_q     <= '0;
      raw_q     <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      deb_q     <= '0;
      deb_upd_q <= 1'b0;
      state_q   <= ST_IDLE;
      held_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      frame_q   <= 1'b0;
      rep_q     <= '0;
`endif
    end else begin
      row_s1_q  <= row_in;
      row_s2_q  <= row_s1_q;
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      deb_q     <= deb_d;
      deb_upd_q <= deb_upd_d;
      state_q   <= state_d;
      held_q    <= held_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
`ifdef KEYPAD_REPEAT_EN
      frame_q   <= frame_done;
      rep_q     <= rep_d;
`endif
    end
  end

  assign col_out      = ~(4'b0001 << col_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_down  = (state_q == ST_HELD);
  assign kp.overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_rx.sv
// tb_keypad_scan_rx
//   Frame-level bench for keypad_scan_rx (SCAN_DIV=4, DEBOUNCE=2,
//   REPEAT_FRAMES=3). A virtual keypad drives row_in from col_out and a
//   16-bit pressed-key pattern that changes only at frame boundaries. The
//   reference model keeps the frame history and accepts a key state when
//   exactly DEBOUNCE trailing frames are identical.
module tb_keypad_scan_rx;
  localparam int SD  = 4;
  localparam int DB  = 2;
  localparam int RF  = 3;
  localparam logic [15:0] ONE = 16'd1;

  logic       clk = 1'b0;
  logic       cpu_reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [15:0] pat;

  keypad_scan_rx_if kp_if ();

  keypad_scan_rx #(.SCAN_DIV(SD), .DEBOUNCE(DB), .REPEAT_FRAMES(RF)) dut (
    .clk       (clk),
    .cpu_reset (cpu_reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .kp        (kp_if.master)
  );

  always #5 clk = ~clk;

  // Virtual keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = '1;
    for (int unsigned c = 0; c < 4; c++) begin
      if (col_out == 4'(~(4'b0001 << c))) begin
        for (int unsigned r = 0; r < 4; r++) begin
          if (pat[c*4 + r]) row_in[r] = 1'b0;
        end
      end
    end
  end

  int chk = 0;
  int err = 0;

  // Reference model state
  logic [15:0] hist[$];
  int          m_held;
  bit          m_multi;
  bit          m_valid, m_ovr;
  logic [3:0]  m_code;
  bit          ev_pend;
  logic [3:0]  ev_code;
  int          m_rep;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    m_held = -1; m_multi = 0; m_valid = 0; m_ovr = 0; m_code = '0;
    ev_pend = 0; ev_code = '0; m_rep = 0;
  endtask

  function automatic int key_index(input logic [15:0] v);
    int k = 0;
    for (int i = 0; i < 16; i++) if (v[i]) k = i;
    return k;
  endfunction

  task automatic post_event(input int k);
    ev_pend = 1;
    ev_code = 4'(k);
  endtask

  // Frame completion: debounce acceptance, key rules and auto-repeat.
  task automatic model_frame_end(input logic [15:0] p);
    int  run;
    bit  was_held;
    hist.push_back(p);
    run = 1;
    for (int i = hist.size() - 2; i >= 0; i--) begin
      if (hist[i] != p) break;
      run++;
    end
    was_held = (m_held >= 0);
    if (run == DB) begin
      if (m_held < 0 && !m_multi) begin
        if ($countones(p) == 1) begin
          m_held = key_index(p);
          post_event(m_held);
        end else if (p != '0) begin
          m_multi = 1;
        end
      end else if (m_held >= 0) begin
        if (p == '0) m_held = -1;
        else if (p != (ONE << m_held)) begin m_held = -1; m_multi = 1; end
      end else if (p == '0) begin
        m_multi = 0;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    if (m_held < 0) m_rep = 0;
    else if (was_held) begin
      m_rep++;
      if (m_rep == 2*RF) begin
        post_event(m_held);
        m_rep = RF;
      end
    end
`else
    if (was_held) m_rep = 0;
`endif
  endtask

  // First cycle of a frame: pending event meets the ack driven in that cycle.
  task automatic model_start(input bit a0);
    if (ev_pend) begin
      if (!m_valid || a0) begin
        m_code = ev_code;
        if (m_valid) m_ovr = 0;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      ev_pend = 0;
    end else if (a0 && m_valid) begin
      m_valid = 0; m_ovr = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".key_valid"}, 16'(kp_if.key_valid), 16'(m_valid));
    check({tag, ".key_code"},  16'(kp_if.key_code),  16'(m_code));
    check({tag, ".key_down"},  16'(kp_if.key_down),  16'(m_held >= 0));
    check({tag, ".overrun"},   16'(kp_if.overrun),   16'(m_ovr));
  endtask

  // One full frame (16 cycles) starting at column 0, dwell 0.
  task automatic frame(input string tag, input logic [15:0] p, input bit a0, input bit am);
    pat = p;
    model_start(a0);
    kp_if.key_ack = a0;
    cyc(1);
    kp_if.key_ack = 1'b0;
    cyc(7);
    kp_if.key_ack = am;
    cyc(1);
    kp_if.key_ack = 1'b0;
    if (am && m_valid) begin m_valid = 0; m_ovr = 0; end
    cyc(3);
    check_outputs(tag);
    cyc(4);
    model_frame_end(p);
  endtask

  task automatic frames(input string tag, input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) frame(tag, p, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] p;
    int          hold;
    cpu_reset     = 1'b1;
    kp_if.key_ack = 1'b0;
    pat           = '0;
    model_reset();
    cyc(3);
    cpu_reset = 1'b0;

    // Reset state and column sequence.
    for (int i = 0; i < 4; i++) begin
      check("reset.col_out", 16'(col_out), 16'(4'(~(4'b0001 << i))));
      cyc(SD);
    end
    check("reset.col_wrap", 16'(col_out), 16'(4'b1110));
    check_outputs("reset");
    model_frame_end('0);

    // Single press of key 6, ack, release.
    frames("single", ONE << 6, 3);
    check("single.code6", 16'(kp_if.key_code), 16'd6);
    frame("single_ack", ONE << 6, 1'b0, 1'b1);
    frames("single_rel", '0, 3);

    // Two keys, partial release, then clean press of key 0.
    frames("two", (ONE << 0) | (ONE << 15), 3);
    frames("two_part", ONE << 0, 3);
    frames("two_rel", '0, 3);
    frames("key0", ONE << 0, 3);
    frame("key0_ack", ONE << 0, 1'b0, 1'b1);
    frames("key0_rel", '0, 3);

    // Overrun, then simultaneous ack and event clears it.
    frames("ovr5", ONE << 5, 2);
    frames("ovr5r", '0, 2);
    frames("ovr9", ONE << 9, 2);
    frames("ovr9r", '0, 3);
    check("ovr.code5", 16'(kp_if.key_code), 16'd5);
    frames("ovr3", ONE << 3, 2);
    frame("ovr3_coinc", ONE << 3, 1'b1, 1'b0);
    frame("ovr3_ack", ONE << 3, 1'b0, 1'b1);
    frames("ovr3r", '0, 3);
    frames("ovr5b", ONE << 5, 2);
    frames("ovr5br", '0, 2);
    frames("ovr9b", ONE << 9, 2);
    frame("ovr_ack", '0, 1'b0, 1'b1);
    frames("ovr_idle", '0, 2);

    // Bounce: a different snapshot every frame never settles.
    for (int i = 0; i < 6; i++) frame("bounce", (i % 2) ? (ONE << 7) : '0, 1'b0, 1'b0);
    frames("bounce_end", '0, 2);

    // Long hold of key 10 with an ack every frame (auto-repeat when enabled).
    for (int i = 0; i < 15; i++) frame("hold10", ONE << 10, 1'b0, 1'b1);
    frames("hold10_rel", '0, 3);

    // Randomized key patterns and acknowledges.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3, 0))
        0:       p = '0;
        1, 2:    p = ONE << $urandom_range(15, 0);
        default: p = (ONE << $urandom_range(15, 0)) | (ONE << $urandom_range(15, 0));
      endcase
      hold = $urandom_range(4, 1);
      for (int h = 0; h < hold; h++) begin
        frame("rand", p, ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0));
      end
    end

    // Mid-frame reset during column 2 with an event pending.
    frames("mr_rel", '0, 3);
    frame("mr_ack", '0, 1'b0, 1'b1);
    frames("mr_press", ONE << 6, 3);
    pat = ONE << 6;
    model_start(1'b0);
    cyc(8);
    check("mr.col2", 16'(col_out), 16'(4'b1011));
    cpu_reset = 1'b1;
    cyc(1);
    cpu_reset = 1'b0;
    model_reset();
    check("mr.col_out", 16'(col_out), 16'(4'b1110));
    check_outputs("mr");
    pat = '0;
    cyc(16);
    model_frame_end('0);
    frames("mr_after", ONE << 1, 3);
    frames("mr_after_rel", '0, 2);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
